// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-index width, opcodes and hazard FSM encoding.
package mips_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and taken-branch flush control for the ID stage, with event counters.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             ex_mem_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             hazard_detected,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_e  state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       lu;

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = id_ex_memread && (id_ex_rt != '0) &&
              ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    hazard_detected = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;

    if (reset) begin
      pc_write        = 1'b0;
      if_id_write     = 1'b0;
      hazard_detected = 1'b1;
      state_d         = HZ_RUN;
      rem_d           = 2'd0;
    end else if (ex_mem_branch_taken) begin
      // Taken branch overrides any load-use stall: the stalled instructions are squashed.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = HZ_RUN;
      rem_d        = 2'd0;
    end else begin
      unique case (state_q)
        HZ_RUN: begin
          if (lu) begin
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            hazard_detected = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = HZ_STALL;
              rem_d   = 2'(STALL_CYCLES - 1);
            end
          end
        end
        HZ_STALL: begin
          pc_write        = 1'b0;
          if_id_write     = 1'b0;
          hazard_detected = 1'b1;
          rem_d           = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = HZ_RUN;
          end
        end
        default: begin
          state_d = HZ_RUN;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(reset),
    .en   (hazard_detected),
    .count(stall_count)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .clear(reset),
    .en   (ex_mem_branch_taken),
    .count(flush_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Four hazard_unit builds (STALL_CYCLES 1/2/3, and a 4-bit counter build) share one
// stimulus stream and are compared each cycle against a cycle-level behavioural model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       if_id_uses_rt, id_ex_memread, ex_mem_branch_taken;

  logic        pw0, iw0, hd0, fa0, fb0, fc0;
  logic        pw1, iw1, hd1, fa1, fb1, fc1;
  logic        pw2, iw2, hd2, fa2, fb2, fc2;
  logic        pw3, iw3, hd3, fa3, fb3, fc3;
  logic [15:0] sc0, fl0, sc1, fl1, sc2, fl2;
  logic [3:0]  sc3, fl3;

  int tests = 0;
  int fails = 0;

  int scyc [4] = '{1, 2, 3, 1};
  int cmax [4] = '{65535, 65535, 65535, 15};
  int busy [4];
  int m_sc [4];
  int m_fc [4];

  always #5 clk = ~clk;

  hazard_unit #(.STALL_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .ex_mem_branch_taken(ex_mem_branch_taken), .pc_write(pw0), .if_id_write(iw0),
    .hazard_detected(hd0), .if_id_flush(fa0), .id_ex_flush(fb0), .ex_mem_flush(fc0),
    .stall_count(sc0), .flush_count(fl0));

  hazard_unit #(.STALL_CYCLES(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .ex_mem_branch_taken(ex_mem_branch_taken), .pc_write(pw1), .if_id_write(iw1),
    .hazard_detected(hd1), .if_id_flush(fa1), .id_ex_flush(fb1), .ex_mem_flush(fc1),
    .stall_count(sc1), .flush_count(fl1));

  hazard_unit #(.STALL_CYCLES(3), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .ex_mem_branch_taken(ex_mem_branch_taken), .pc_write(pw2), .if_id_write(iw2),
    .hazard_detected(hd2), .if_id_flush(fa2), .id_ex_flush(fb2), .ex_mem_flush(fc2),
    .stall_count(sc2), .flush_count(fl2));

  hazard_unit #(.STALL_CYCLES(1), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .ex_mem_branch_taken(ex_mem_branch_taken), .pc_write(pw3), .if_id_write(iw3),
    .hazard_detected(hd3), .if_id_flush(fa3), .id_ex_flush(fb3), .ex_mem_flush(fc3),
    .stall_count(sc3), .flush_count(fl3));

  // One clock cycle: drive inputs, check all builds mid-cycle, advance the model.
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic [4:0] ert,
                      input logic br);
    logic [5:0] act, exp_v;
    int         act_s, act_f;
    bit         lu, stall;
    reset               = r;
    if_id_rs            = rs;
    if_id_rt            = rt;
    if_id_uses_rt       = urt;
    id_ex_memread       = mr;
    id_ex_rt            = ert;
    ex_mem_branch_taken = br;
    @(negedge clk);
    lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin act = {pw0, iw0, hd0, fa0, fb0, fc0}; act_s = int'(sc0); act_f = int'(fl0); end
        1: begin act = {pw1, iw1, hd1, fa1, fb1, fc1}; act_s = int'(sc1); act_f = int'(fl1); end
        2: begin act = {pw2, iw2, hd2, fa2, fb2, fc2}; act_s = int'(sc2); act_f = int'(fl2); end
        default: begin
          act = {pw3, iw3, hd3, fa3, fb3, fc3}; act_s = int'(sc3); act_f = int'(fl3);
        end
      endcase

      tests++;
      assert (act_s === m_sc[k]) else begin
        fails++;
        $error("FAIL stall_count dut%0d t=%0t got %0d want %0d", k, $time, act_s, m_sc[k]);
      end
      tests++;
      assert (act_f === m_fc[k]) else begin
        fails++;
        $error("FAIL flush_count dut%0d t=%0t got %0d want %0d", k, $time, act_f, m_fc[k]);
      end

      // exp_v = {pc_write, if_id_write, hazard_detected, if_id, id_ex, ex_mem flushes}
      stall = 1'b0;
      if (r) begin
        exp_v = 6'b001000;
        busy[k] = 0;
      end else if (br) begin
        exp_v = 6'b110111;
        busy[k] = 0;
      end else if (busy[k] > 0) begin
        stall = 1'b1;
        busy[k]--;
      end else if (lu) begin
        stall = 1'b1;
        busy[k] = scyc[k] - 1;
      end else begin
        exp_v = 6'b110000;
      end
      if (stall) exp_v = 6'b001000;

      tests++;
      assert (act === exp_v) else begin
        fails++;
        $error("FAIL outputs dut%0d t=%0t got %b want %b", k, $time, act, exp_v);
      end

      if (r) begin
        m_sc[k] = 0;
        m_fc[k] = 0;
      end else begin
        if (stall && m_sc[k] < cmax[k]) m_sc[k]++;
        if (br && m_fc[k] < cmax[k]) m_fc[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd5, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      busy[k] = 0;
      m_sc[k] = 0;
      m_fc[k] = 0;
    end
    reset = 1'b1;
    if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0;
    if_id_uses_rt = 1'b0; id_ex_memread = 1'b0; ex_mem_branch_taken = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // lw $2 in EX, ID reads rs=$2
    step(1'b0, 5'd2, 5'd7, 1'b0, 1'b1, 5'd2, 1'b0);
    repeat (4) idle();

    // $0 never hazards; rt match ignored when ID does not read rt
    step(1'b0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0);
    step(1'b0, 5'd5, 5'd3, 1'b0, 1'b1, 5'd3, 1'b0);
    // rt match that does count
    step(1'b0, 5'd5, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0);
    repeat (3) idle();

    // load-use and taken branch together
    step(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1);
    repeat (2) idle();

    // branch in the 2nd stall cycle, then reset during a later stall
    step(1'b0, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0);
    step(1'b0, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b1);
    idle();
    step(1'b0, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0);
    step(1'b1, 5'd8, 5'd1, 1'b0, 1'b0, 5'd8, 1'b0);
    repeat (3) idle();

    // random traffic over a small register range so matches are frequent
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    // drive both counters of the 4-bit build past saturation
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (21) step(1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
    repeat (21) step(1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
    repeat (2) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: run did not reach its end, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
